// File: rtl/bind_command_dispatcher.sv
// bind_command_dispatcher: queued bind-command initiator that walks each command word by word
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready               command queue handshake
//   cmd_hva/cmd_hvb/cmd_hvc/cmd_len   command operand bases and word count
//   valid, hva, hvb, hvc, hv_offset   per-word request to the bind generator
//   done                              generator word-complete pulse
//   busy, cmd_done, cmd_abort         command status
//   timeout_err, err_clear            sticky watchdog error and its clear
module bind_command_dispatcher #(
    parameter int HV_ADDRESS_WIDTH = 20,
    parameter int CMD_FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hva,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvb,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvc,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_len,
    output logic                        valid,
    output logic [HV_ADDRESS_WIDTH-1:0] hva,
    output logic [HV_ADDRESS_WIDTH-1:0] hvb,
    output logic [HV_ADDRESS_WIDTH-1:0] hvc,
    output logic [HV_ADDRESS_WIDTH-1:0] hv_offset,
    input  logic                        done,
    output logic                        busy,
    output logic                        cmd_done,
    output logic                        cmd_abort,
    output logic                        timeout_err,
    input  logic                        err_clear
);
    localparam int W   = HV_ADDRESS_WIDTH;
    localparam int AW  = $clog2(CMD_FIFO_DEPTH);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;

    state_t         state, state_n;
    logic [4*W-1:0] fifo [CMD_FIFO_DEPTH];
    logic [4*W-1:0] head;
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [W-1:0]   len;
    logic [WDW-1:0] wd;
    logic           abort, full, empty, push, pop, last, expire, fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty     = wr_ptr == rd_ptr;
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = state == IDLE && !empty;
    assign head      = fifo[rd_ptr[AW-1:0]];
    assign last      = hv_offset == len - W'(1);
    assign expire    = TIMEOUT_CYCLES != 0 && wd >= WD_LIMIT;
    // A done in the expiry cycle completes the word normally.
    assign fire      = state == WAIT && !done && expire;

    assign valid     = state == ISSUE;
    assign busy      = state != IDLE;
    assign cmd_done  = state == COMPLETE;
    assign cmd_abort = cmd_done && abort;

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[AW-1:0]] <= {cmd_hva, cmd_hvb, cmd_hvc, cmd_len};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = pop ? (head[W-1:0] == '0 ? COMPLETE : ISSUE) : IDLE;
            ISSUE:    state_n = WAIT;
            WAIT:     state_n = done ? (last ? COMPLETE : ISSUE) : (expire ? COMPLETE : WAIT);
            COMPLETE: state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hva         <= '0;
            hvb         <= '0;
            hvc         <= '0;
            len         <= '0;
            hv_offset   <= '0;
            wd          <= '0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                <= rd_ptr + 1'b1;
                {hva, hvb, hvc, len}  <= head;
                hv_offset             <= '0;
                wd                    <= '0;
            end
            // The watchdog also counts the ISSUE cycle, so a word times out
            // TIMEOUT_CYCLES cycles after its valid strobe.
            if (state == ISSUE) wd <= wd + 1'b1;
            if (state == WAIT) begin
                wd <= done ? '0 : wd + 1'b1;
                if (done && !last) hv_offset <= hv_offset + 1'b1;
            end
            abort       <= fire ? 1'b1 : (state == COMPLETE ? 1'b0 : abort);
            timeout_err <= fire || (timeout_err && !err_clear);
        end
    end
endmodule

// File: doc/bind_command_dispatcher.md
Name: bind_command_dispatcher

Overview:
Kernel-mapper-side initiator for the bind kernel generator. It accepts bind commands (hypervector A, B and C base addresses plus a length in words) through a valid/ready queue. For each command it walks hv_offset from 0 to len-1, issuing one valid strobe per word and waiting for the generator's done before advancing. It reports per-command completion and abort, and runs a watchdog against a hung kernel.

Parameters:
HV_ADDRESS_WIDTH, 20, width of hypervector base addresses, offsets and lengths
CMD_FIFO_DEPTH, 4, command queue entries (power of two, >=2)
TIMEOUT_CYCLES, 1024, max cycles waiting for done per word; 0 disables the watchdog

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  queue can accept a command
cmd_hva  in  HV_ADDRESS_WIDTH  base address of operand A
cmd_hvb  in  HV_ADDRESS_WIDTH  base address of operand B
cmd_hvc  in  HV_ADDRESS_WIDTH  base address of result C
cmd_len  in  HV_ADDRESS_WIDTH  number of words to bind
valid  out  1  one-cycle strobe to generator: process word at hv_offset
hva  out  HV_ADDRESS_WIDTH  operand A base to generator
hvb  out  HV_ADDRESS_WIDTH  operand B base to generator
hvc  out  HV_ADDRESS_WIDTH  result base to generator
hv_offset  out  HV_ADDRESS_WIDTH  current word offset
done  in  1  generator word-complete pulse
busy  out  1  a command is in flight (state != IDLE)
cmd_done  out  1  one-cycle pulse at end of each command
cmd_abort  out  1  valid with cmd_done; 1 = command ended by timeout
timeout_err  out  1  sticky watchdog error flag
err_clear  in  1  clears timeout_err

Behaviour:
- Reset (async, reset_n=0): FIFO empty; state IDLE; valid, busy, cmd_done, cmd_abort, timeout_err = 0; hva, hvb, hvc, hv_offset = 0; cmd_ready = 1 once reset is released.
- Queue: cmd_ready = !full. A push occurs when cmd_valid & cmd_ready. cmd_ready depends only on full, so there is no push-when-full even if a pop happens in the same cycle. A push into an empty queue is visible to the FSM on the next cycle.
- FSM states: IDLE, ISSUE, WAIT, COMPLETE.
- IDLE: if the queue is not empty, pop and latch hva/hvb/hvc/len, set hv_offset=0, clear the watchdog. If len==0 go to COMPLETE, otherwise go to ISSUE.
- ISSUE: valid=1 for exactly this cycle, then go to WAIT. hva/hvb/hvc/hv_offset are stable from ISSUE until the done that completes the word.
- WAIT: the watchdog increments each cycle.
  - On done, if hv_offset==len-1, go to COMPLETE.
  - On done otherwise, increment hv_offset and go to ISSUE.
  - Else, if TIMEOUT_CYCLES!=0 and the watchdog reaches TIMEOUT_CYCLES-1: set timeout_err, set the abort flag, go to COMPLETE.
- COMPLETE: cmd_done=1 for one cycle, cmd_abort = abort flag; clear the abort flag; go to IDLE.
- Latency: push at cycle N -> pop at N+1 -> valid at N+2. After done at cycle M, the next valid is at M+1 (ISSUE).
- A done pulse seen outside WAIT is ignored. A done and a timeout in the same cycle: done wins, no error.
- timeout_err: sticky. err_clear clears it; if a timeout fires in the same cycle as err_clear, set wins. Aborted commands leave remaining words unissued; queued commands continue normally.
- Width rules: hv_offset never exceeds len-1, so there is no wrap. cmd_len = 2^HV_ADDRESS_WIDTH-1 is legal.
- Reset mid-operation: aborts immediately with no cmd_done pulse; queue contents are discarded.
- busy = (state != IDLE).

Test Plan:
- Single command hva=0x100, hvb=0x200, hvc=0x300, len=3; generator answers done 2 cycles after each valid -> valid strobes at hv_offset 0,1,2; one cmd_done with cmd_abort=0; hva/hvb/hvc stable throughout.
- len=0 command -> no valid strobe; cmd_done pulses 2 cycles after push; busy high for exactly 1 cycle.
- Push 5 commands back-to-back with CMD_FIFO_DEPTH=4 while the generator holds off done -> cmd_ready=0 after the 4th queued entry; 5th accepted only after a pop; all 5 complete in order.
- TIMEOUT_CYCLES=8, generator never asserts done -> cmd_done with cmd_abort=1 8 cycles after valid; timeout_err=1 until err_clear; next queued command runs normally.
- Done asserted in the same cycle the watchdog expires -> no abort, timeout_err stays 0; stray done while IDLE -> no effect.
- reset_n low during WAIT on a len=4 command -> all outputs 0 asynchronously, queue empty, no cmd_done, cmd_ready=1 after release.
